// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizes and MIPS register name constants
package regfile_pkg;
    localparam int REG_ZERO   = 0;
    localparam int REG_COUNT  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam logic [4:0] REG_AT = 5'd1;
    localparam logic [4:0] REG_V0 = 5'd2;
    localparam logic [4:0] REG_V1 = 5'd3;
    localparam logic [4:0] REG_A0 = 5'd4;
    localparam logic [4:0] REG_A1 = 5'd5;
    localparam logic [4:0] REG_A2 = 5'd6;
    localparam logic [4:0] REG_A3 = 5'd7;
    localparam logic [4:0] REG_T0 = 5'd8;
    localparam logic [4:0] REG_T1 = 5'd9;
    localparam logic [4:0] REG_T2 = 5'd10;
    localparam logic [4:0] REG_T3 = 5'd11;
    localparam logic [4:0] REG_T4 = 5'd12;
    localparam logic [4:0] REG_T5 = 5'd13;
    localparam logic [4:0] REG_T6 = 5'd14;
    localparam logic [4:0] REG_T7 = 5'd15;
    localparam logic [4:0] REG_S0 = 5'd16;
    localparam logic [4:0] REG_S1 = 5'd17;
    localparam logic [4:0] REG_S2 = 5'd18;
    localparam logic [4:0] REG_S3 = 5'd19;
    localparam logic [4:0] REG_S4 = 5'd20;
    localparam logic [4:0] REG_S5 = 5'd21;
    localparam logic [4:0] REG_S6 = 5'd22;
    localparam logic [4:0] REG_S7 = 5'd23;
    localparam logic [4:0] REG_T8 = 5'd24;
    localparam logic [4:0] REG_T9 = 5'd25;
    localparam logic [4:0] REG_K0 = 5'd26;
    localparam logic [4:0] REG_K1 = 5'd27;
    localparam logic [4:0] REG_GP = 5'd28;
    localparam logic [4:0] REG_SP = 5'd29;
    localparam logic [4:0] REG_FP = 5'd30;
    localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: decode/write-back side bundle of the register file
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH      = DATA_WIDTH,
    parameter int DEPTH_LOG2 = ADDR_WIDTH
);
    logic [DEPTH_LOG2-1:0] read_addr1;
    logic [DEPTH_LOG2-1:0] read_addr2;
    logic [DEPTH_LOG2-1:0] write_addr;
    logic [WIDTH-1:0]      write_data;
    logic                  reg_write;
    logic [WIDTH-1:0]      read_data1;
    logic [WIDTH-1:0]      read_data2;
    modport master (
        output read_addr1, read_addr2, write_addr, write_data, reg_write,
        input  read_data1, read_data2
    );
    modport slave (
        input  read_addr1, read_addr2, write_addr, write_data, reg_write,
        output read_data1, read_data2
    );
endinterface

// File: rtl/regfile_register32r.sv
// register32r: enable register with asynchronous active-low clear
module register32r
    import regfile_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             wrenable,
    input  logic             clk,
    input  logic             reset_n
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            q <= '0;
        else if (wrenable)
            q <= d;
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 MIPS register file, two async read ports, one write port, optional bypass
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH      = DATA_WIDTH,
    parameter int DEPTH_LOG2 = ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
    input logic      clk,
    input logic      reset_n,
    regfile_if.slave bus
);
    localparam int N = 2 ** DEPTH_LOG2;
    logic [WIDTH-1:0] entry_q [N];
    logic             wr_live, hit1, hit2;
    assign entry_q[0] = '0;
    for (genvar i = 1; i < N; i++) begin : g_reg
        register32r #(.WIDTH(WIDTH)) u_reg (
            .q        (entry_q[i]),
            .d        (bus.write_data),
            .wrenable (bus.reg_write && bus.write_addr == DEPTH_LOG2'(i)),
            .clk      (clk),
            .reset_n  (reset_n)
        );
    end
    // bypass only for a real write outside reset, never for $zero
    assign wr_live = BYPASS && reset_n && bus.reg_write && bus.write_addr != '0;
    assign hit1 = wr_live && bus.read_addr1 == bus.write_addr;
    assign hit2 = wr_live && bus.read_addr2 == bus.write_addr;
    assign bus.read_data1 = hit1 ? bus.write_data : entry_q[bus.read_addr1];
    assign bus.read_data2 = hit2 ? bus.write_data : entry_q[bus.read_addr2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for the bypassed and non-bypassed register file
module tb_regfile;
    import regfile_pkg::*;
    logic clk = 1'b0;
    logic reset_n;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    logic [31:0] mdl [32];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    regfile_if bus ();
    regfile_if nbus ();
    assign nbus.read_addr1 = bus.read_addr1;
    assign nbus.read_addr2 = bus.read_addr2;
    assign nbus.write_addr = bus.write_addr;
    assign nbus.write_data = bus.write_data;
    assign nbus.reg_write  = bus.reg_write;
    regfile #(.BYPASS(1'b1)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    regfile #(.BYPASS(1'b0)) u_nbp (.clk(clk), .reset_n(reset_n), .bus(nbus.slave));
    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic we);
        @(negedge clk);
        bus.reg_write = we; bus.write_addr = a; bus.write_data = d;
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
        if (we && a != 5'd0) mdl[a] = d;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            bus.read_addr1 = 5'(a); bus.read_addr2 = 5'(31 - a);
            exp_q.push_back(32'h0); exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front(); chk_cnt++;
            if (bus.read_data1 !== e) $display("FAIL init_p1 a=%0d got=%h exp=%h", a, bus.read_data1, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (bus.read_data2 !== e) $display("FAIL init_p2 a=%0d got=%h exp=%h", 31 - a, bus.read_data2, e); else pass_cnt++;
        end
        @(negedge clk) reset_n = 1'b1;
        wr(REG_A1, 32'hDEADBEEF, 1'b1);
        bus.read_addr1 = REG_A1;
        exp_q.push_back(32'hDEADBEEF);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL preload got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        #2 reset_n = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL async_clr got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data1 !== e) $display("FAIL async_clr_nbp got=%h exp=%h", nbus.read_data1, e); else pass_cnt++;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_basic();
        wr(REG_T0, 32'h00FFFAAA, 1'b1);
        bus.read_addr1 = REG_T0; bus.read_addr2 = REG_T1;
        exp_q.push_back(32'h00FFFAAA); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL basic_p1 got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data2 !== e) $display("FAIL basic_p2 got=%h exp=%h", bus.read_data2, e); else pass_cnt++;
    endtask

    task automatic test_write_disabled();
        wr(REG_T0, 32'h00FFF000, 1'b0);
        bus.read_addr1 = REG_T0; bus.read_addr2 = REG_T0;
        exp_q.push_back(32'h00FFFAAA); exp_q.push_back(32'h00FFFAAA);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL wr_dis got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data2 !== e) $display("FAIL wr_dis_nbp got=%h exp=%h", nbus.read_data2, e); else pass_cnt++;
    endtask

    task automatic test_zero();
        @(negedge clk);
        bus.reg_write = 1'b1; bus.write_addr = 5'd0; bus.write_data = 32'hFFFFFFFF;
        bus.read_addr1 = 5'd0; bus.read_addr2 = 5'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL zero_byp_p1 got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data2 !== e) $display("FAIL zero_byp_p2 got=%h exp=%h", bus.read_data2, e); else pass_cnt++;
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL zero_after got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data2 !== e) $display("FAIL zero_after_nbp got=%h exp=%h", nbus.read_data2, e); else pass_cnt++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus.reg_write = 1'b1; bus.write_addr = REG_RA; bus.write_data = 32'h12345678;
        bus.read_addr1 = REG_RA; bus.read_addr2 = REG_RA;
        exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
        exp_q.push_back(mdl[REG_RA]); exp_q.push_back(mdl[REG_RA]);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL byp_p1 got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data2 !== e) $display("FAIL byp_p2 got=%h exp=%h", bus.read_data2, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data1 !== e) $display("FAIL nbp_pre_p1 got=%h exp=%h", nbus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data2 !== e) $display("FAIL nbp_pre_p2 got=%h exp=%h", nbus.read_data2, e); else pass_cnt++;
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
        mdl[REG_RA] = 32'h12345678;
        exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data1 !== e) $display("FAIL nbp_post_p1 got=%h exp=%h", nbus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data2 !== e) $display("FAIL nbp_post_p2 got=%h exp=%h", nbus.read_data2, e); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int a = 1; a < 32; a++) begin
            d = $urandom;
            @(negedge clk);
            bus.reg_write = 1'b1; bus.write_addr = 5'(a); bus.write_data = d;
            bus.read_addr1 = 5'(a); bus.read_addr2 = 5'(a - 1);
            exp_q.push_back(d); exp_q.push_back(mdl[a - 1]); exp_q.push_back(mdl[a]);
            #1 e = exp_q.pop_front(); chk_cnt++;
            if (bus.read_data1 !== e) $display("FAIL b2b_byp a=%0d got=%h exp=%h", a, bus.read_data1, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (bus.read_data2 !== e) $display("FAIL b2b_prev a=%0d got=%h exp=%h", a - 1, bus.read_data2, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (nbus.read_data1 !== e) $display("FAIL b2b_nbp a=%0d got=%h exp=%h", a, nbus.read_data1, e); else pass_cnt++;
            @(posedge clk);
            mdl[a] = d;
        end
        #1 bus.reg_write = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.read_addr1 = 5'(a); bus.read_addr2 = 5'(31 - a);
            exp_q.push_back(mdl[a]); exp_q.push_back(mdl[31 - a]);
            #1 e = exp_q.pop_front(); chk_cnt++;
            if (bus.read_data1 !== e) $display("FAIL sweep_p1 a=%0d got=%h exp=%h", a, bus.read_data1, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (nbus.read_data2 !== e) $display("FAIL sweep_p2 a=%0d got=%h exp=%h", 31 - a, nbus.read_data2, e); else pass_cnt++;
        end
    endtask

    task automatic test_reset_race();
        @(negedge clk);
        bus.reg_write = 1'b1; bus.write_addr = REG_V1; bus.write_data = 32'hA5A5A5A5;
        bus.read_addr1 = REG_V1; bus.read_addr2 = REG_V1;
        @(posedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL race_held got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data2 !== e) $display("FAIL race_held_nbp got=%h exp=%h", nbus.read_data2, e); else pass_cnt++;
        bus.reg_write = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); chk_cnt++;
        if (bus.read_data1 !== e) $display("FAIL race_rel got=%h exp=%h", bus.read_data1, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (nbus.read_data2 !== e) $display("FAIL race_rel_nbp got=%h exp=%h", nbus.read_data2, e); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        bus.read_addr1 = '0; bus.read_addr2 = '0; bus.write_addr = '0;
        bus.write_data = '0; bus.reg_write = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_write_disabled();
        test_zero();
        test_bypass();
        test_back_to_back();
        test_reset_race();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry by 32-bit MIPS register file for the Lab3 CPU core.
- Consumes the register32 storage element (the zero-register variant for entry 0).
- Sits between instruction decode (register addresses) and the ALU/write-back path (operands, result).
- Provides two combinational read ports, one clocked write port, optional write-through bypass, and asynchronous clear.

Parameters:
- WIDTH, 32, data width of every entry.
- DEPTH_LOG2, 5, address width; 2**DEPTH_LOG2 entries, fixed at 32 for MIPS.
- BYPASS, 1, 1 = a read of the address being written this cycle returns write_data; 0 = it returns the old contents.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset; clears all entries.
- read_addr1  input  DEPTH_LOG2  rs address.
- read_addr2  input  DEPTH_LOG2  rt address.
- write_addr  input  DEPTH_LOG2  rd/rt destination address.
- write_data  input  WIDTH  value to store.
- reg_write  input  1  write enable.
- read_data1  output  WIDTH  contents selected by read_addr1.
- read_data2  output  WIDTH  contents selected by read_addr2.

Behaviour:
- Storage:
  - Entries 1..31 are WIDTH-bit registers.
  - Entry 0 ($zero) always reads 0 and is never written. It needs no state, or is a register32zero instance.
- Reset:
  - Falling edge of reset_n clears entries 1..31 to 0 immediately, with no clk edge required.
  - While reset_n=0, writes are ignored and both read ports return 0. Bypass is suppressed.
- Write:
  - On a rising clk edge with reset_n=1, reg_write=1 and write_addr!=0: entry[write_addr] <= write_data.
  - All other entries hold.
  - New value is visible on the non-bypassed read path after that edge (1-cycle write latency).
- Write to address 0: no state change; a read of address 0 still returns 0.
- reg_write=0: no entry changes, whatever write_addr and write_data are.
- Read:
  - Purely combinational from the address inputs and stored state. Zero cycle latency, no clock involvement.
  - Port 1 and port 2 are independent. Both may select the same address, including the one being written.
- Bypass (BYPASS=1):
  - If reg_write=1, reset_n=1, write_addr!=0 and read_addrN==write_addr, then read_dataN = write_data in the same cycle.
  - Otherwise read_dataN = stored entry.
  - Bypass never applies to address 0.
- Bypass off (BYPASS=0): read returns the pre-edge contents until the edge, then the new contents.
- Reset mid-operation: a reset_n assertion coincident with a clk edge and reg_write=1 leaves the entry at 0 (reset wins). Deassertion is synchronised externally; the block needs no internal synchroniser.
- No X propagation requirement beyond out-of-reset behaviour. All entries are defined after the first reset.

Decomposition:
- Shared package/header constants:
  - REG_ZERO=0, REG_COUNT=32, DATA_WIDTH=32.
  - MIPS register name constants (REG_AT=1, REG_V0=2 … REG_RA=31), used by decode and the bench.
- Sub-module: register32r, a 32-bit enable register with async active-low clear (q, d, wrenable, clk, reset_n).
  - Instantiated 31 times with a generate loop.
  - Write enables come from a 5-to-32 one-hot decode of write_addr gated by reg_write.
- Read muxes are 32:1 selects inside regfile.
- Bypass compare and select is a small per-port block inside regfile.

Test Plan:
- Reset: drive reset_n=0 mid-cycle after preloading entry 5 = 32'hDEADBEEF → read_data1 (addr 5) = 0 before the next clk edge. Every address 0..31 reads 0.
- Basic write/read: write 32'hFFFAAA to addr 8 with reg_write=1, one edge → read_addr1=8 gives 32'hFFFAAA. read_addr2=9 gives 0.
- Write disabled: reg_write=0, write_addr=8, write_data=32'hFFF000, one edge → addr 8 still 32'hFFFAAA.
- $zero: reg_write=1, write_addr=0, write_data=32'hFFFFFFFF, one edge → both ports reading addr 0 give 0, including the same cycle with BYPASS=1.
- Bypass and dual port, same cycle as a write of 32'h12345678 to addr 31 (read_addr1=read_addr2=31):
  - BYPASS=1: both read 32'h12345678 before the edge.
  - BYPASS=0: both read the old value (0) before the edge and 32'h12345678 after it.
- Reset vs write race: reset_n falls at the same time as a clk edge with write to addr 3 = 32'hA5A5A5A5 → addr 3 reads 0 while reset is held and after release.
